// File: rtl/scarv_cop_top.sv
// -----------------------------------------------------------------------------
// scarv_cop_top
// Small instruction-set-extension coprocessor attached to a host CPU.
// Holds sixteen 32-bit coprocessor registers (CPR) and executes one
// instruction at a time: register moves, ALU/shift ops and word loads/stores
// over a simple stallable memory bus.
//
// Ports
//   g_clk, g_resetn        clock, synchronous active-low reset
//   g_clk_req              clock request (busy or instruction offered)
//   cpu_insn_req/ack       CPU offers instruction / CPU takes response
//   cop_insn_ack           coprocessor accepts instruction (idle)
//   cpu_abort_req          abort the in-flight instruction
//   cpu_insn_enc, cpu_rs1  encoded instruction and GPR rs1 value
//   cop_wen/waddr/wdata    GPR writeback, valid with cop_insn_rsp
//   cop_result, cop_insn_rsp  completion code and response valid
//   cop_mem_*              word-wide memory bus (cen/wen/addr/wdata/ben out,
//                          rdata/stall/error in)
// -----------------------------------------------------------------------------
module scarv_cop_top (
    input  logic        g_clk,
    input  logic        g_resetn,
    output logic        g_clk_req,
    input  logic        cpu_insn_req,
    output logic        cop_insn_ack,
    input  logic        cpu_abort_req,
    input  logic [31:0] cpu_insn_enc,
    input  logic [31:0] cpu_rs1,
    output logic        cop_wen,
    output logic [4:0]  cop_waddr,
    output logic [31:0] cop_wdata,
    output logic [2:0]  cop_result,
    output logic        cop_insn_rsp,
    input  logic        cpu_insn_ack,
    output logic        cop_mem_cen,
    output logic        cop_mem_wen,
    output logic [31:0] cop_mem_addr,
    output logic [31:0] cop_mem_wdata,
    output logic [3:0]  cop_mem_ben,
    input  logic [31:0] cop_mem_rdata,
    input  logic        cop_mem_stall,
    input  logic        cop_mem_error
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEM  = 2'd1,
        ST_RSP  = 2'd2
    } state_t;

    localparam logic [2:0] RES_SUCCESS     = 3'd0;
    localparam logic [2:0] RES_ABORT       = 3'd1;
    localparam logic [2:0] RES_BAD_INSN    = 3'd2;
    localparam logic [2:0] RES_LD_MISALIGN = 3'd3;
    localparam logic [2:0] RES_ST_MISALIGN = 3'd4;
    localparam logic [2:0] RES_LD_BUS_ERR  = 3'd5;
    localparam logic [2:0] RES_ST_BUS_ERR  = 3'd6;

    localparam logic [4:0] OP_MV2GPR = 5'd0;
    localparam logic [4:0] OP_LDW    = 5'd10;
    localparam logic [4:0] OP_STW    = 5'd11;

    state_t      state_r;
    logic [31:0] cpr_r [16];

    logic        ack_r;
    logic        rsp_r;
    logic [2:0]  result_r;
    logic        wen_r;
    logic [4:0]  waddr_r;
    logic [31:0] wdata_r;
    logic        cen_r;
    logic        mem_wen_r;
    logic [31:0] mem_addr_r;
    logic [31:0] mem_wdata_r;
    logic [3:0]  mem_ben_r;
    logic [3:0]  pend_crd_r;   // load destination while the bus transfer runs
    logic        pend_st_r;    // in-flight memory op is a store

    logic [4:0]  op_s;
    logic [3:0]  crs1_s;
    logic [3:0]  crs2_s;
    logic [3:0]  crd_s;
    logic [4:0]  rd_s;
    logic        bad_s;
    logic        is_mem_s;
    logic        is_st_s;
    logic        misalign_s;
    logic [31:0] src1_s;
    logic [31:0] src2_s;
    logic [63:0] rot_s;
    logic [31:0] alu_s;
    logic        alu_wr_s;
    logic        unused_s;

    // Instruction decode and datapath for the instruction currently offered.
    always_comb begin
        op_s       = cpu_insn_enc[31:27];
        crs2_s     = cpu_insn_enc[23:20];
        crs1_s     = cpu_insn_enc[18:15];
        rd_s       = cpu_insn_enc[11:7];
        crd_s      = cpu_insn_enc[10:7];
        bad_s      = (cpu_insn_enc[6:0] != 7'b0101011) || (op_s > 5'd11);
        is_mem_s   = (op_s == OP_LDW) || (op_s == OP_STW);
        is_st_s    = (op_s == OP_STW);
        misalign_s = (cpu_rs1[1:0] != 2'b00);
        src1_s     = cpr_r[crs1_s];
        src2_s     = cpr_r[crs2_s];
        // Rotate right by shifting a doubled copy; shift amount 0 is harmless.
        rot_s      = {src1_s, src1_s} >> src2_s[4:0];
        alu_wr_s   = 1'b1;
        case (op_s)
            5'd1:    alu_s = cpu_rs1;
            5'd2:    alu_s = src1_s + src2_s;
            5'd3:    alu_s = src1_s - src2_s;
            5'd4:    alu_s = src1_s ^ src2_s;
            5'd5:    alu_s = src1_s & src2_s;
            5'd6:    alu_s = src1_s | src2_s;
            5'd7:    alu_s = src1_s << src2_s[4:0];
            5'd8:    alu_s = src1_s >> src2_s[4:0];
            5'd9:    alu_s = rot_s[31:0];
            default: begin
                alu_s    = 32'h0000_0000;
                alu_wr_s = 1'b0;
            end
        endcase
    end

    // Reserved encoding fields carry no meaning for this instruction set.
    assign unused_s = ^{cpu_insn_enc[26:24], cpu_insn_enc[19], cpu_insn_enc[14:12]};

    // Control FSM, CPR file and all registered outputs.
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            state_r     <= ST_IDLE;
            for (int i = 0; i < 16; i++) begin
                cpr_r[i] <= 32'h0000_0000;
            end
            ack_r       <= 1'b1;
            rsp_r       <= 1'b0;
            result_r    <= RES_SUCCESS;
            wen_r       <= 1'b0;
            waddr_r     <= 5'd0;
            wdata_r     <= 32'h0000_0000;
            cen_r       <= 1'b0;
            mem_wen_r   <= 1'b0;
            mem_addr_r  <= 32'h0000_0000;
            mem_wdata_r <= 32'h0000_0000;
            mem_ben_r   <= 4'b0000;
            pend_crd_r  <= 4'd0;
            pend_st_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (cpu_insn_req) begin
                        ack_r   <= 1'b0;
                        wen_r   <= 1'b0;
                        state_r <= ST_RSP;
                        rsp_r   <= 1'b1;
                        if (cpu_abort_req) begin
                            result_r <= RES_ABORT;
                        end else if (bad_s) begin
                            result_r <= RES_BAD_INSN;
                        end else if (is_mem_s && misalign_s) begin
                            result_r <= is_st_s ? RES_ST_MISALIGN : RES_LD_MISALIGN;
                        end else if (is_mem_s) begin
                            // Aligned access: bus signals stay frozen until done.
                            state_r     <= ST_MEM;
                            rsp_r       <= 1'b0;
                            cen_r       <= 1'b1;
                            mem_wen_r   <= is_st_s;
                            mem_addr_r  <= {cpu_rs1[31:2], 2'b00};
                            mem_wdata_r <= src1_s;
                            mem_ben_r   <= is_st_s ? 4'b1111 : 4'b0000;
                            pend_crd_r  <= crd_s;
                            pend_st_r   <= is_st_s;
                        end else begin
                            result_r <= RES_SUCCESS;
                            if (alu_wr_s) begin
                                cpr_r[crd_s] <= alu_s;
                            end
                            if (op_s == OP_MV2GPR) begin
                                wen_r   <= 1'b1;
                                waddr_r <= rd_s;
                                wdata_r <= src1_s;
                            end
                        end
                    end
                end
                ST_MEM: begin
                    // A completing transfer takes priority over a late abort.
                    if (!cop_mem_stall) begin
                        state_r   <= ST_RSP;
                        rsp_r     <= 1'b1;
                        cen_r     <= 1'b0;
                        mem_wen_r <= 1'b0;
                        if (cop_mem_error) begin
                            result_r <= pend_st_r ? RES_ST_BUS_ERR : RES_LD_BUS_ERR;
                        end else begin
                            result_r <= RES_SUCCESS;
                            if (!pend_st_r) begin
                                cpr_r[pend_crd_r] <= cop_mem_rdata;
                            end
                        end
                    end else if (cpu_abort_req) begin
                        state_r   <= ST_RSP;
                        rsp_r     <= 1'b1;
                        cen_r     <= 1'b0;
                        mem_wen_r <= 1'b0;
                        result_r  <= RES_ABORT;
                    end
                end
                ST_RSP: begin
                    if (cpu_insn_ack) begin
                        state_r <= ST_IDLE;
                        rsp_r   <= 1'b0;
                        wen_r   <= 1'b0;
                        ack_r   <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    rsp_r   <= 1'b0;
                    wen_r   <= 1'b0;
                    cen_r   <= 1'b0;
                    ack_r   <= 1'b1;
                end
            endcase
        end
    end

    assign g_clk_req     = (state_r != ST_IDLE) || cpu_insn_req;
    assign cop_insn_ack  = ack_r;
    assign cop_insn_rsp  = rsp_r;
    assign cop_result    = result_r;
    assign cop_wen       = wen_r;
    assign cop_waddr     = waddr_r;
    assign cop_wdata     = wdata_r;
    assign cop_mem_cen   = cen_r;
    assign cop_mem_wen   = mem_wen_r;
    assign cop_mem_addr  = mem_addr_r;
    assign cop_mem_wdata = mem_wdata_r;
    assign cop_mem_ben   = mem_ben_r;

endmodule

// File: tb/tb_scarv_cop_top.sv
// -----------------------------------------------------------------------------
// tb_scarv_cop_top
// Directed self-checking bench for scarv_cop_top. Each instruction goes
// through a full handshake; CPR contents are observed through mv2gpr.
// -----------------------------------------------------------------------------
module tb_scarv_cop_top;

    logic        g_clk;
    logic        g_resetn;
    logic        g_clk_req;
    logic        cpu_insn_req;
    logic        cop_insn_ack;
    logic        cpu_abort_req;
    logic [31:0] cpu_insn_enc;
    logic [31:0] cpu_rs1;
    logic        cop_wen;
    logic [4:0]  cop_waddr;
    logic [31:0] cop_wdata;
    logic [2:0]  cop_result;
    logic        cop_insn_rsp;
    logic        cpu_insn_ack;
    logic        cop_mem_cen;
    logic        cop_mem_wen;
    logic [31:0] cop_mem_addr;
    logic [31:0] cop_mem_wdata;
    logic [3:0]  cop_mem_ben;
    logic [31:0] cop_mem_rdata;
    logic        cop_mem_stall;
    logic        cop_mem_error;

    int n_vec;
    int n_err;

    // Values captured by run_insn for the last instruction.
    logic [2:0]  r_res;
    logic        r_wen;
    logic [4:0]  r_waddr;
    logic [31:0] r_wdata;
    int          r_cen_cycles;
    logic        m_wen;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_ben;
    logic        m_stable;

    scarv_cop_top dut (
        .g_clk         (g_clk),
        .g_resetn      (g_resetn),
        .g_clk_req     (g_clk_req),
        .cpu_insn_req  (cpu_insn_req),
        .cop_insn_ack  (cop_insn_ack),
        .cpu_abort_req (cpu_abort_req),
        .cpu_insn_enc  (cpu_insn_enc),
        .cpu_rs1       (cpu_rs1),
        .cop_wen       (cop_wen),
        .cop_waddr     (cop_waddr),
        .cop_wdata     (cop_wdata),
        .cop_result    (cop_result),
        .cop_insn_rsp  (cop_insn_rsp),
        .cpu_insn_ack  (cpu_insn_ack),
        .cop_mem_cen   (cop_mem_cen),
        .cop_mem_wen   (cop_mem_wen),
        .cop_mem_addr  (cop_mem_addr),
        .cop_mem_wdata (cop_mem_wdata),
        .cop_mem_ben   (cop_mem_ben),
        .cop_mem_rdata (cop_mem_rdata),
        .cop_mem_stall (cop_mem_stall),
        .cop_mem_error (cop_mem_error)
    );

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [4:0] op, input logic [3:0] crs2,
                                        input logic [3:0] crs1, input logic [4:0] rd);
        enc = {op, 3'b000, crs2, 1'b0, crs1, 3'b000, rd, 7'b0101011};
    endfunction

    // Issue one instruction and complete its handshake.
    // abort_at: 0 = abort in accept cycle, k>0 = abort in k-th bus cycle, 99 = never.
    task automatic run_insn(input logic [31:0] e, input logic [31:0] rs1, input int abort_at,
                            input int stalls, input logic [31:0] rdata, input logic err);
        int  k;
        bit  got;
        logic [2:0]  h_res;
        logic [31:0] h_wdata;
        logic        h_wen;
        k = 0;
        got = 1'b0;
        r_cen_cycles = 0;
        m_stable = 1'b1;
        @(negedge g_clk);
        cpu_insn_req  = 1'b1;
        cpu_insn_enc  = e;
        cpu_rs1       = rs1;
        cpu_abort_req = (abort_at == 0);
        @(posedge g_clk);
        #1;
        cpu_insn_req  = 1'b0;
        cpu_abort_req = 1'b0;
        cpu_rs1       = 32'hDEAD_BEEF;
        cpu_insn_enc  = 32'h0000_0000;
        for (int c = 0; c < 60; c++) begin
            @(negedge g_clk);
            if (cop_insn_rsp) begin
                got = 1'b1;
                break;
            end
            if (cop_mem_cen) begin
                if (k == 0) begin
                    m_wen   = cop_mem_wen;
                    m_addr  = cop_mem_addr;
                    m_wdata = cop_mem_wdata;
                    m_ben   = cop_mem_ben;
                end else if (cop_mem_wen !== m_wen || cop_mem_addr !== m_addr ||
                             cop_mem_wdata !== m_wdata || cop_mem_ben !== m_ben) begin
                    m_stable = 1'b0;
                end
                r_cen_cycles++;
                cop_mem_stall = (k < stalls);
                cpu_abort_req = (abort_at == k + 1);
                cop_mem_rdata = rdata;
                cop_mem_error = err;
                k++;
            end else begin
                cpu_abort_req = 1'b0;
                cop_mem_stall = 1'b0;
            end
        end
        cop_mem_stall = 1'b0;
        cop_mem_error = 1'b0;
        cpu_abort_req = 1'b0;
        if (!got) begin
            check_eq("rsp_timeout", 32'd0, 32'd1);
            r_res = 3'd7;
            r_wen = 1'b0;
            r_waddr = 5'd0;
            r_wdata = 32'd0;
        end else begin
            r_res   = cop_result;
            r_wen   = cop_wen;
            r_waddr = cop_waddr;
            r_wdata = cop_wdata;
            h_res   = cop_result;
            h_wdata = cop_wdata;
            h_wen   = cop_wen;
            @(negedge g_clk);
            check_eq("rsp_hold", {27'd0, cop_insn_rsp, cop_wen, cop_result},
                     {27'd0, 1'b1, h_wen, h_res});
            check_eq("rsp_hold_wdata", cop_wdata, h_wdata);
            cpu_insn_ack = 1'b1;
            @(posedge g_clk);
            #1;
            cpu_insn_ack = 1'b0;
            @(negedge g_clk);
            check_eq("rsp_clear", {30'd0, cop_insn_rsp, cop_insn_ack}, {30'd0, 1'b0, 1'b1});
        end
    endtask

    // Read a CPR through mv2gpr (rd=5) and compare.
    task automatic read_cpr(input string tag, input logic [3:0] idx, input logic [31:0] exp);
        run_insn(enc(5'd0, 4'd0, idx, 5'd5), 32'd0, 99, 0, 32'd0, 1'b0);
        check_eq(tag, {26'd0, r_wen, r_waddr}, {26'd0, 1'b1, 5'd5});
        check_eq(tag, r_wdata, exp);
    endtask

    task automatic set_cpr(input logic [3:0] idx, input logic [31:0] v);
        run_insn(enc(5'd1, 4'd0, 4'd0, {1'b0, idx}), v, 99, 0, 32'd0, 1'b0);
    endtask

    // ALU op into CPR12, then read back.
    task automatic alu_chk(input string tag, input logic [4:0] op, input logic [3:0] a,
                           input logic [3:0] b, input logic [31:0] exp);
        run_insn(enc(op, b, a, 5'd12), 32'd0, 99, 0, 32'd0, 1'b0);
        check_eq(tag, {29'd0, r_res}, 32'd0);
        read_cpr(tag, 4'd12, exp);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        g_resetn      = 1'b0;
        cpu_insn_req  = 1'b0;
        cpu_abort_req = 1'b0;
        cpu_insn_enc  = 32'd0;
        cpu_rs1       = 32'd0;
        cpu_insn_ack  = 1'b0;
        cop_mem_rdata = 32'd0;
        cop_mem_stall = 1'b0;
        cop_mem_error = 1'b0;
        repeat (3) @(posedge g_clk);
        @(negedge g_clk);
        check_eq("reset_outs", {25'd0, cop_insn_rsp, cop_wen, cop_result, cop_mem_cen, cop_mem_wen},
                 32'd0);
        check_eq("reset_ack_clkreq", {30'd0, cop_insn_ack, g_clk_req}, {30'd0, 1'b1, 1'b0});
        g_resetn = 1'b1;

        // Move to COP and back.
        set_cpr(4'd3, 32'h1234_5678);
        check_eq("mv2cop_res", {28'd0, r_wen, r_res}, 32'd0);
        run_insn(enc(5'd0, 4'd0, 4'd3, 5'd5), 32'd0, 99, 0, 32'd0, 1'b0);
        check_eq("mv2gpr_ctl", {23'd0, r_wen, r_waddr, r_res}, {23'd0, 1'b1, 5'd5, 3'd0});
        check_eq("mv2gpr_data", r_wdata, 32'h1234_5678);
        run_insn(enc(5'd0, 4'd0, 4'd0, 5'd31), 32'd0, 99, 0, 32'd0, 1'b0);
        check_eq("mv2gpr_rd31", {23'd0, r_wen, r_waddr, r_res}, {23'd0, 1'b1, 5'd31, 3'd0});

        // ALU and shifts.
        set_cpr(4'd1, 32'hFFFF_FFFF);
        set_cpr(4'd2, 32'h0000_0001);
        run_insn(enc(5'd2, 4'd2, 4'd1, 5'd4), 32'd0, 99, 0, 32'd0, 1'b0);
        read_cpr("add_wrap", 4'd4, 32'h0000_0000);
        set_cpr(4'd1, 32'h0000_0001);
        run_insn(enc(5'd9, 4'd2, 4'd1, 5'd6), 32'd0, 99, 0, 32'd0, 1'b0);
        read_cpr("ror1", 4'd6, 32'h8000_0000);
        alu_chk("sub", 5'd3, 4'd4, 4'd2, 32'hFFFF_FFFF);
        set_cpr(4'd9, 32'h7FFF_FFFF);
        set_cpr(4'd10, 32'h0000_0024);
        alu_chk("xor", 5'd4, 4'd9, 4'd6, 32'hFFFF_FFFF);
        alu_chk("and", 5'd5, 4'd9, 4'd3, 32'h1234_5678);
        alu_chk("or", 5'd6, 4'd6, 4'd3, 32'h9234_5678);
        alu_chk("sll", 5'd7, 4'd9, 4'd10, 32'hFFFF_FFF0);
        alu_chk("srl", 5'd8, 4'd9, 4'd10, 32'h07FF_FFFF);
        alu_chk("ror4", 5'd9, 4'd3, 4'd10, 32'h8123_4567);
        // Destination equals both sources: old value used.
        run_insn(enc(5'd2, 4'd1, 4'd1, 5'd1), 32'd0, 99, 0, 32'd0, 1'b0);
        read_cpr("add_self", 4'd1, 32'h0000_0002);

        // Misaligned memory ops.
        run_insn(enc(5'd10, 4'd0, 4'd0, 5'd7), 32'h0000_1002, 99, 0, 32'd0, 1'b0);
        check_eq("ld_misalign", {29'd0, r_res}, 32'd3);
        check_eq("ld_misalign_cen", r_cen_cycles, 32'd0);
        run_insn(enc(5'd11, 4'd0, 4'd3, 5'd0), 32'h0000_0101, 99, 0, 32'd0, 1'b0);
        check_eq("st_misalign", {29'd0, r_res}, 32'd4);

        // Store with three stall cycles.
        run_insn(enc(5'd11, 4'd0, 4'd3, 5'd0), 32'h0000_0100, 99, 3, 32'd0, 1'b0);
        check_eq("st_res", {29'd0, r_res}, 32'd0);
        check_eq("st_cycles", r_cen_cycles, 32'd4);
        check_eq("st_addr", m_addr, 32'h0000_0100);
        check_eq("st_wdata", m_wdata, 32'h1234_5678);
        check_eq("st_ctl", {26'd0, m_stable, m_wen, m_ben}, {26'd0, 1'b1, 1'b1, 4'b1111});

        // Load with one stall.
        run_insn(enc(5'd10, 4'd0, 4'd0, 5'd13), 32'h0000_0200, 99, 1, 32'hCAFE_BABE, 1'b0);
        check_eq("ld_res", {29'd0, r_res}, 32'd0);
        check_eq("ld_ctl", {26'd0, m_stable, m_wen, m_ben}, {26'd0, 1'b1, 1'b0, 4'b0000});
        check_eq("ld_addr", m_addr, 32'h0000_0200);
        read_cpr("ld_val", 4'd13, 32'hCAFE_BABE);

        // Load aborted during stall.
        run_insn(enc(5'd10, 4'd0, 4'd0, 5'd13), 32'h0000_0300, 2, 5, 32'h1111_1111, 1'b0);
        check_eq("ld_abort_res", {29'd0, r_res}, 32'd1);
        check_eq("ld_abort_cycles", r_cen_cycles, 32'd2);
        read_cpr("ld_abort_cpr", 4'd13, 32'hCAFE_BABE);

        // Bus errors.
        run_insn(enc(5'd10, 4'd0, 4'd0, 5'd13), 32'h0000_0400, 99, 0, 32'h2222_2222, 1'b1);
        check_eq("ld_buserr", {29'd0, r_res}, 32'd5);
        read_cpr("ld_buserr_cpr", 4'd13, 32'hCAFE_BABE);
        run_insn(enc(5'd11, 4'd0, 4'd3, 5'd0), 32'h0000_0404, 99, 2, 32'd0, 1'b1);
        check_eq("st_buserr", {29'd0, r_res}, 32'd6);

        // Bad instructions.
        run_insn(32'h0000_0033, 32'd0, 99, 0, 32'd0, 1'b0);
        check_eq("bad_opcode", {29'd0, r_res}, 32'd2);
        run_insn(enc(5'd12, 4'd0, 4'd0, 5'd3), 32'd0, 99, 0, 32'd0, 1'b0);
        check_eq("bad_op12", {29'd0, r_res}, 32'd2);
        read_cpr("bad_no_write", 4'd3, 32'h1234_5678);

        // Abort in accept cycle.
        run_insn(enc(5'd1, 4'd0, 4'd0, 5'd14), 32'h5A5A_5A5A, 0, 0, 32'd0, 1'b0);
        check_eq("abort_accept", {29'd0, r_res}, 32'd1);
        read_cpr("abort_accept_cpr", 4'd14, 32'h0000_0000);

        // Abort coinciding with completing transfer: transfer wins.
        run_insn(enc(5'd10, 4'd0, 4'd0, 5'd15), 32'h0000_0500, 1, 0, 32'h5555_AAAA, 1'b0);
        check_eq("abort_race_res", {29'd0, r_res}, 32'd0);
        read_cpr("abort_race_cpr", 4'd15, 32'h5555_AAAA);

        // Reset in the middle of a stalled store.
        @(negedge g_clk);
        cpu_insn_req  = 1'b1;
        cpu_insn_enc  = enc(5'd11, 4'd0, 4'd3, 5'd0);
        cpu_rs1       = 32'h0000_0600;
        @(posedge g_clk);
        #1;
        cpu_insn_req  = 1'b0;
        cop_mem_stall = 1'b1;
        @(negedge g_clk);
        check_eq("midrst_busy", {30'd0, cop_mem_cen, g_clk_req}, {30'd0, 1'b1, 1'b1});
        g_resetn = 1'b0;
        @(posedge g_clk);
        #1;
        g_resetn      = 1'b1;
        cop_mem_stall = 1'b0;
        @(negedge g_clk);
        check_eq("midrst_quiet", {28'd0, cop_mem_cen, cop_insn_rsp, cop_wen, cop_insn_ack},
                 {28'd0, 1'b0, 1'b0, 1'b0, 1'b1});
        read_cpr("midrst_cpr", 4'd3, 32'h0000_0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
